// File: rtl/rsa_job_sequencer.sv
// Job front-end for the RSA control core: sequences inverter and mod-exp phases, caches the last key, aborts a hung core.
// Accept-to-pulse is one cycle; the result is held on res_valid until res_ready, and no job is accepted meanwhile.
module rsa_job_sequencer #(
    parameter int WIDTH          = 128,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [WIDTH-1:0]     job_p,
    input  logic [WIDTH-1:0]     job_q,
    input  logic                 job_encrypt_decrypt,
    input  logic [2*WIDTH-1:0]   job_msg,
    output logic [WIDTH-1:0]     core_p,
    output logic [WIDTH-1:0]     core_q,
    output logic                 core_encrypt_decrypt,
    output logic [2*WIDTH-1:0]   core_msg,
    output logic                 core_reset_inverter,
    output logic                 core_reset_mod_exp,
    input  logic                 core_inverter_finish,
    input  logic                 core_mod_exp_finish,
    input  logic [2*WIDTH-1:0]   core_msg_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   res_msg,
    output logic                 res_timeout
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INV_RST,
        S_INV_WAIT,
        S_EXP_RST,
        S_EXP_WAIT,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 key_valid_q, key_valid_d;
    logic [WIDTH-1:0]     last_p_q, last_p_d;
    logic [WIDTH-1:0]     last_q_q, last_q_d;
    logic                 last_ed_q, last_ed_d;
    logic [WIDTH-1:0]     core_p_q, core_p_d;
    logic [WIDTH-1:0]     core_q_q, core_q_d;
    logic                 core_ed_q, core_ed_d;
    logic [2*WIDTH-1:0]   core_msg_q, core_msg_d;
    logic [2*WIDTH-1:0]   res_msg_q, res_msg_d;
    logic                 res_timeout_q, res_timeout_d;

    logic [WD_W-1:0]      wd_inc;
    logic                 wd_guard;
    logic                 wd_limit;
    logic                 key_hit;

    // wd_q is zero only in the first wait cycle, which doubles as the stale-finish mask.
    assign wd_inc   = wd_q + WD_W'(1);
    assign wd_guard = (wd_q == '0);
    assign wd_limit = (wd_inc == WD_W'(TIMEOUT_CYCLES));
    assign key_hit  = key_valid_q && (job_p == last_p_q) && (job_q == last_q_q)
                      && (job_encrypt_decrypt == last_ed_q);

    always_comb begin
        state_d       = state_q;
        wd_d          = wd_q;
        key_valid_d   = key_valid_q;
        last_p_d      = last_p_q;
        last_q_d      = last_q_q;
        last_ed_d     = last_ed_q;
        core_p_d      = core_p_q;
        core_q_d      = core_q_q;
        core_ed_d     = core_ed_q;
        core_msg_d    = core_msg_q;
        res_msg_d     = res_msg_q;
        res_timeout_d = res_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    core_p_d   = job_p;
                    core_q_d   = job_q;
                    core_ed_d  = job_encrypt_decrypt;
                    core_msg_d = job_msg;
                    state_d    = key_hit ? S_EXP_RST : S_INV_RST;
                end
            end
            S_INV_RST: begin
                wd_d    = '0;
                state_d = S_INV_WAIT;
            end
            S_INV_WAIT: begin
                wd_d = wd_inc;
                if (!wd_guard && core_inverter_finish) begin
                    key_valid_d = 1'b1;
                    last_p_d    = core_p_q;
                    last_q_d    = core_q_q;
                    last_ed_d   = core_ed_q;
                    state_d     = S_EXP_RST;
                end else if (wd_limit) begin
                    res_msg_d     = '0;
                    res_timeout_d = 1'b1;
                    key_valid_d   = 1'b0;
                    state_d       = S_DONE;
                end
            end
            S_EXP_RST: begin
                wd_d    = '0;
                state_d = S_EXP_WAIT;
            end
            S_EXP_WAIT: begin
                wd_d = wd_inc;
                if (!wd_guard && core_mod_exp_finish) begin
                    res_msg_d     = core_msg_out;
                    res_timeout_d = 1'b0;
                    state_d       = S_DONE;
                end else if (wd_limit) begin
                    res_msg_d     = '0;
                    res_timeout_d = 1'b1;
                    key_valid_d   = 1'b0;
                    state_d       = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wd_q          <= '0;
            key_valid_q   <= 1'b0;
            last_p_q      <= '0;
            last_q_q      <= '0;
            last_ed_q     <= 1'b0;
            core_p_q      <= '0;
            core_q_q      <= '0;
            core_ed_q     <= 1'b0;
            core_msg_q    <= '0;
            res_msg_q     <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wd_q          <= wd_d;
            key_valid_q   <= key_valid_d;
            last_p_q      <= last_p_d;
            last_q_q      <= last_q_d;
            last_ed_q     <= last_ed_d;
            core_p_q      <= core_p_d;
            core_q_q      <= core_q_d;
            core_ed_q     <= core_ed_d;
            core_msg_q    <= core_msg_d;
            res_msg_q     <= res_msg_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    // Gating with reset keeps job_ready low while reset is held, even though state is already IDLE.
    assign job_ready            = (state_q == S_IDLE) && !reset;
    assign core_reset_inverter  = (state_q == S_INV_RST);
    assign core_reset_mod_exp   = (state_q == S_EXP_RST);
    assign res_valid            = (state_q == S_DONE);
    assign core_p               = core_p_q;
    assign core_q               = core_q_q;
    assign core_encrypt_decrypt = core_ed_q;
    assign core_msg             = core_msg_q;
    assign res_msg              = res_msg_q;
    assign res_timeout          = res_timeout_q;

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Bench for rsa_job_sequencer: a latency-programmable core model plus a per-job timeline model checked every cycle.
module tb_rsa_job_sequencer;

    localparam int W  = 128;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             job_valid = 1'b0;
    logic             job_ready;
    logic [W-1:0]     job_p = '0, job_q = '0;
    logic             job_encrypt_decrypt = 1'b0;
    logic [2*W-1:0]   job_msg = '0;
    logic [W-1:0]     core_p, core_q;
    logic             core_encrypt_decrypt;
    logic [2*W-1:0]   core_msg;
    logic             core_reset_inverter, core_reset_mod_exp;
    logic             core_inverter_finish = 1'b0, core_mod_exp_finish = 1'b0;
    logic [2*W-1:0]   core_msg_out = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [2*W-1:0]   res_msg;
    logic             res_timeout;

    rsa_job_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_p(job_p), .job_q(job_q), .job_encrypt_decrypt(job_encrypt_decrypt), .job_msg(job_msg),
        .core_p(core_p), .core_q(core_q), .core_encrypt_decrypt(core_encrypt_decrypt), .core_msg(core_msg),
        .core_reset_inverter(core_reset_inverter), .core_reset_mod_exp(core_reset_mod_exp),
        .core_inverter_finish(core_inverter_finish), .core_mod_exp_finish(core_mod_exp_finish),
        .core_msg_out(core_msg_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_msg(res_msg), .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc + 1);
        end
    endtask

    // Stand-in for the real core: XOR with {p,q} is its own inverse, so a round trip returns the message.
    function automatic logic [2*W-1:0] core_fn(input logic [2*W-1:0] m, input logic [W-1:0] p, input logic [W-1:0] q);
        return m ^ {p, q};
    endfunction

    int  c_ilat = 3, c_elat = 3;
    bit  c_inever = 0, c_stale = 0;
    int  inv_p = -100000, exp_p = -100000;
    int  n_inv_pulse = 0, n_exp_pulse = 0;

    always @(negedge clk) begin
        int now_c;
        logic fin_e;
        now_c = cyc + 1;
        if (core_reset_inverter) begin inv_p = now_c; n_inv_pulse++; end
        if (core_reset_mod_exp)  begin exp_p = now_c; n_exp_pulse++; end
        core_inverter_finish = c_stale || (!c_inever && now_c >= inv_p + c_ilat);
        fin_e                = c_stale || (now_c >= exp_p + c_elat);
        core_mod_exp_finish  = fin_e;
        core_msg_out         = fin_e ? core_fn(core_msg, core_p, core_q) : {8{32'hDEADBEEF}};
    end

    // Expected timeline of the job in flight, in absolute cycle numbers.
    bit             tracking = 0;
    bit             in_reset = 1;
    int             m_inv, m_exp, m_done;
    bit             m_to;
    logic [2*W-1:0] m_res, m_msg;
    logic [W-1:0]   m_p, m_q;
    logic           m_ed;
    bit             kv_m = 0;
    logic [W-1:0]   lp_m, lq_m;
    logic           led_m;

    always @(negedge clk) begin
        int now;
        now = cyc + 1;
        if (!in_reset) begin
            if (tracking) begin
                check("inv_pulse", core_reset_inverter, now == m_inv);
                check("exp_pulse", core_reset_mod_exp, now == m_exp);
                check("res_valid", res_valid, now >= m_done);
                check("job_ready_busy", job_ready, 0);
                check("core_p", core_p, m_p);
                check("core_q", core_q, m_q);
                check("core_ed", core_encrypt_decrypt, m_ed);
                check("core_msg", core_msg, m_msg);
                if (now >= m_done) begin
                    check("res_msg", res_msg, m_res);
                    check("res_timeout", res_timeout, m_to);
                end
            end else begin
                check("job_ready_idle", job_ready, 1);
                check("res_valid_idle", res_valid, 0);
                check("inv_pulse_idle", core_reset_inverter, 0);
                check("exp_pulse_idle", core_reset_mod_exp, 0);
            end
        end
    end

    task automatic start_job(input logic [W-1:0] p, input logic [W-1:0] q, input logic ed,
                             input logic [2*W-1:0] msg, output int a);
        int   w, le, pm;
        logic hit;
        job_p = p; job_q = q; job_encrypt_decrypt = ed; job_msg = msg; job_valid = 1'b1;
        w = 0;
        while (!job_ready && w < 100) begin @(posedge clk); #1; w++; end
        if (!job_ready) begin
            check("accept_wait", 0, 1);
            job_valid = 1'b0;
            a = -1;
            return;
        end
        @(posedge clk); #1;
        a = cyc;
        job_valid = 1'b0;
        job_p = {4{$urandom}}; job_q = {4{$urandom}}; job_msg = {8{$urandom}};
        job_encrypt_decrypt = $urandom_range(0, 1);
        hit = kv_m && p == lp_m && q == lq_m && ed == led_m;
        m_p = p; m_q = q; m_ed = ed; m_msg = msg;
        m_inv = -1; m_exp = -1; m_to = 0; pm = -1;
        if (hit) pm = a + 1;
        else begin
            m_inv = a + 1;
            le = c_stale ? 0 : (c_inever ? TO + 100 : c_ilat);
            if (le < 2) le = 2;
            if (le > TO) begin m_to = 1; m_done = m_inv + TO + 1; end
            else pm = m_inv + le + 1;
        end
        if (pm >= 0) begin
            m_exp = pm;
            le = c_stale ? 0 : c_elat;
            if (le < 2) le = 2;
            if (le > TO) begin m_to = 1; m_done = pm + TO + 1; end
            else m_done = pm + le + 1;
        end
        m_res = m_to ? '0 : core_fn(msg, p, q);
        if (m_to) kv_m = 0;
        else if (!hit) begin kv_m = 1; lp_m = p; lq_m = q; led_m = ed; end
        tracking = 1;
    endtask

    task automatic finish_job(input int hold, output logic [2*W-1:0] res, output int rise);
        int w;
        w = 0;
        while (!res_valid && w < 300) begin @(posedge clk); #1; w++; end
        if (!res_valid) begin
            check("res_wait", 0, 1);
            tracking = 0; res = '0; rise = -1;
            return;
        end
        rise = cyc + 1;
        res  = res_msg;
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            check("hold_res_msg", res_msg, res);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        tracking  = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_job_ready"}, job_ready, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_timeout"}, res_timeout, 0);
        check({tag, "_res_msg"}, res_msg, 0);
        check({tag, "_core_pq"}, {core_p, core_q}, 0);
        check({tag, "_core_msg"}, core_msg, 0);
        check({tag, "_ctl"}, {core_encrypt_decrypt, core_reset_inverter, core_reset_mod_exp}, 0);
    endtask

    localparam logic [W-1:0]   SP = 128'd113680897410347;
    localparam logic [W-1:0]   SQ = 128'd7999808077935876437321;
    localparam logic [2*W-1:0] SM = 256'hf03ab37b2857e70000;

    initial begin
        int             a, rise, ni, ne;
        logic [2*W-1:0] r, r1;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        #1;
        check("ready_after_reset", job_ready, 1);
        in_reset = 0;
        @(posedge clk); #1;

        // Small operands with a hand-worked result and latency: inv done at A+4, exp pulse A+5, result at A+10.
        c_ilat = 3; c_elat = 4;
        ni = n_inv_pulse; ne = n_exp_pulse;
        start_job(128'h5, 128'h3, 1'b0, 256'h10, a);
        finish_job(0, r, rise);
        check("pin_res", r, {128'h5, 128'h13});
        check("pin_latency", rise - a, 10);
        check("pin_inv_count", n_inv_pulse - ni, 1);
        check("pin_exp_count", n_exp_pulse - ne, 1);

        c_ilat = 5; c_elat = 7;
        start_job(SP, SQ, 1'b0, SM, a);
        finish_job(0, r1, rise);
        check("full_timeout", res_timeout, 0);
        start_job(SP, SQ, 1'b1, r1, a);
        finish_job(0, r, rise);
        check("round_trip", r, SM);

        // Same key again with a new message: no inverter pulse, mod-exp pulse at A+1.
        c_elat = 4;
        ni = n_inv_pulse;
        start_job(SP, SQ, 1'b1, 256'h1234_5678, a);
        finish_job(0, r, rise);
        check("hit_inv_count", n_inv_pulse - ni, 0);
        check("hit_latency", rise - a, 6);
        check("hit_res", r, 256'h1234_5678 ^ {SP, SQ});
        ni = n_inv_pulse;
        start_job(SP, SQ + 128'd2, 1'b1, 256'h1234_5678, a);
        finish_job(0, r, rise);
        check("newq_inv_count", n_inv_pulse - ni, 1);

        // Inverter finish lands on the 16th wait cycle: finish wins over the watchdog.
        c_ilat = 16; c_elat = 2;
        start_job(128'h9, 128'hA, 1'b0, 256'h77, a);
        finish_job(0, r, rise);
        check("edge_timeout", res_timeout, 0);
        check("edge_latency", rise - a, 21);

        c_inever = 1;
        start_job(128'h7, 128'hB, 1'b0, 256'h55, a);
        finish_job(0, r, rise);
        check("to_flag", res_timeout, 1);
        check("to_res", r, 0);
        check("to_latency", rise - a, 18);
        c_inever = 0; c_ilat = 3; c_elat = 3;
        ni = n_inv_pulse;
        start_job(128'h7, 128'hB, 1'b0, 256'h55, a);
        finish_job(0, r, rise);
        check("after_to_inv_count", n_inv_pulse - ni, 1);
        check("after_to_res", r, {128'h7, 128'hB ^ 128'h55});

        // Both finishes stuck high: only the guard cycles pace the job.
        c_stale = 1;
        ni = n_inv_pulse; ne = n_exp_pulse;
        start_job(128'h21, 128'h22, 1'b0, 256'h99, a);
        finish_job(0, r, rise);
        check("stale_latency", rise - a, 7);
        check("stale_inv_count", n_inv_pulse - ni, 1);
        check("stale_exp_count", n_exp_pulse - ne, 1);
        c_stale = 0;

        start_job(128'h31, 128'h32, 1'b1, 256'hABCD, a);
        finish_job(10, r, rise);
        check("bp_res", r, {128'h31, 128'h32 ^ 128'hABCD});

        // Reset in the middle of EXP_WAIT drops the job and the cached key.
        c_ilat = 2; c_elat = 20;
        start_job(128'h41, 128'h42, 1'b0, 256'h1, a);
        while (cyc + 1 < m_exp + 3) begin @(posedge clk); #1; end
        reset = 1'b1; in_reset = 1; tracking = 0;
        @(posedge clk); #1;
        check_all_zero("midreset");
        reset = 1'b0;
        #1;
        check("ready_after_midreset", job_ready, 1);
        kv_m = 0;
        in_reset = 0;
        c_elat = 3;
        ni = n_inv_pulse;
        start_job(128'h41, 128'h42, 1'b0, 256'h1, a);
        finish_job(0, r, rise);
        check("post_reset_inv_count", n_inv_pulse - ni, 1);
        check("post_reset_res", r, {128'h41, 128'h43});

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

endmodule
